// File: rtl/interp_sched_if.sv
// Source-side sample stream between the PCM source and the interpolator scheduler.
interface interp_sched_if #(
    parameter int unsigned DATA_W = 15
) ();
    logic              s_valid;
    logic [DATA_W-1:0] s_data;
    logic              s_ready;

    modport master (output s_valid, output s_data, input s_ready);
    modport slave  (input s_valid, input s_data, output s_ready);
endinterface

// File: rtl/interp_sched.sv
// Sample-rate scheduler: buffers PCM samples in a small FIFO and releases one onto v_out
// with a single-cycle strobe every OSR clocks.
module interp_sched #(
    parameter int unsigned OSR        = 8,
    parameter int unsigned DATA_W     = 15,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned PRIME_LVL  = 2,
    localparam int unsigned PHASE_W   = (OSR > 1) ? $clog2(OSR) : 1,
    localparam int unsigned FILL_W    = $clog2(FIFO_DEPTH) + 1,
    localparam int unsigned PTR_W     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               enable,
    interp_sched_if.slave      src,
    output logic [DATA_W-1:0]  v_out,
    output logic               sample_strobe,
    output logic [PHASE_W-1:0] phase,
    output logic [FILL_W-1:0]  fill_level,
    output logic               underrun,
    output logic [15:0]        underrun_count,
    output logic               running
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] PRIME = 2'd1;
    localparam logic [1:0] RUN   = 2'd2;

    logic [1:0]         state_q, state_d;
    logic [PHASE_W-1:0] phase_q, phase_d;
    logic [FILL_W-1:0]  fill_q, fill_d;
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [DATA_W-1:0]  mem_q [FIFO_DEPTH];
    logic [DATA_W-1:0]  v_q, v_d;
    logic               strobe_q, strobe_d;
    logic               ur_q, ur_d;
    logic [15:0]        cnt_q, cnt_d;
    logic               push, pop, flush, ready;

    assign ready = enable & (state_q != IDLE) & (fill_q < FILL_W'(FIFO_DEPTH));
    assign push  = src.s_valid & ready;
    assign src.s_ready = ready;

    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        v_d      = v_q;
        strobe_d = 1'b0;
        ur_d     = 1'b0;
        cnt_d    = cnt_q;
        pop      = 1'b0;
        flush    = 1'b0;
        if (!enable) begin
            state_d = IDLE;
            phase_d = '0;
            v_d     = '0;
            flush   = 1'b1;
        end else begin
            case (state_q)
                IDLE: state_d = PRIME;
                PRIME: begin
                    if (fill_q >= FILL_W'(PRIME_LVL)) begin
                        state_d  = RUN;
                        pop      = 1'b1;
                        v_d      = mem_q[rd_ptr_q];
                        strobe_d = 1'b1;
                        phase_d  = '0;
                    end
                end
                RUN: begin
                    if (phase_q == PHASE_W'(OSR - 1)) begin
                        phase_d  = '0;
                        strobe_d = 1'b1;
                        if (fill_q != '0) begin
                            pop = 1'b1;
                            v_d = mem_q[rd_ptr_q];
                        end else begin
                            // No bypass: a sample pushed on this edge waits for the next strobe.
                            ur_d = 1'b1;
                            if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
                        end
                    end else begin
                        phase_d = phase_q + PHASE_W'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        fill_d = fill_q;
        if (flush) begin
            fill_d = '0;
        end else begin
            case ({push, pop})
                2'b10:   fill_d = fill_q + FILL_W'(1);
                2'b01:   fill_d = fill_q - FILL_W'(1);
                default: fill_d = fill_q;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q  <= IDLE;
            phase_q  <= '0;
            fill_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            v_q      <= '0;
            strobe_q <= 1'b0;
            ur_q     <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            fill_q   <= fill_d;
            v_q      <= v_d;
            strobe_q <= strobe_d;
            ur_q     <= ur_d;
            cnt_q    <= cnt_d;
            if (flush) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                if (push) begin
                    wr_ptr_q <= (wr_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
                end
                if (pop) begin
                    rd_ptr_q <= (rd_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
                end
            end
        end
    end

    // Storage needs no reset: occupancy is tracked by fill_q and the pointers.
    always_ff @(posedge clock) begin
        if (push) mem_q[wr_ptr_q] <= src.s_data;
    end

    assign v_out          = v_q;
    assign sample_strobe  = strobe_q;
    assign phase          = phase_q;
    assign fill_level     = fill_q;
    assign underrun       = ur_q;
    assign underrun_count = cnt_q;
    assign running        = (state_q == RUN);
endmodule

// File: tb/tb_interp_sched.sv
// Directed bench for interp_sched: vector table for the prime/run/underrun path, hand
// sequences for full FIFO, enable drop, reset and counter saturation.
module tb_interp_sched;
    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        enable = 1'b0;
    logic [14:0] v_out;
    logic        sample_strobe, underrun, running;
    logic [2:0]  phase;
    logic [2:0]  fill_level;
    logic [15:0] underrun_count;

    logic        clk2 = 1'b0;
    logic        rst2 = 1'b0;
    logic        en2 = 1'b0;
    logic [14:0] v2;
    logic        strb2, ur2, run2;
    logic [0:0]  ph2;
    logic [2:0]  fill2;
    logic [15:0] cnt2;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clock = ~clock;
    always #1 clk2 = ~clk2;

    interp_sched_if #(.DATA_W(15)) src ();
    interp_sched_if #(.DATA_W(15)) src2 ();

    interp_sched #(.OSR(8), .DATA_W(15), .FIFO_DEPTH(4), .PRIME_LVL(2)) dut (
        .clock(clock), .reset(reset), .enable(enable), .src(src.slave),
        .v_out(v_out), .sample_strobe(sample_strobe), .phase(phase),
        .fill_level(fill_level), .underrun(underrun), .underrun_count(underrun_count),
        .running(running)
    );

    // Short strobe period so the 16-bit counter can be driven to saturation.
    interp_sched #(.OSR(2), .DATA_W(15), .FIFO_DEPTH(4), .PRIME_LVL(1)) dut_sat (
        .clock(clk2), .reset(rst2), .enable(en2), .src(src2.slave),
        .v_out(v2), .sample_strobe(strb2), .phase(ph2),
        .fill_level(fill2), .underrun(ur2), .underrun_count(cnt2), .running(run2)
    );

    typedef struct packed {
        logic        run;
        logic        strb;
        logic        ur;
        logic        rdy;
        logic [2:0]  ph;
        logic [2:0]  fill;
        logic [14:0] v;
        logic [15:0] cnt;
    } obs_t;

    typedef struct {
        logic        en;
        logic        sv;
        logic [14:0] sd;
        obs_t        exp;
    } vec_t;

    vec_t vecs[$];

    function automatic obs_t mk(bit run, bit strb, bit ur, bit rdy, int ph, int fill,
                                logic [14:0] v, logic [15:0] cnt);
        obs_t o;
        o.run = run; o.strb = strb; o.ur = ur; o.rdy = rdy;
        o.ph = 3'(ph); o.fill = 3'(fill); o.v = v; o.cnt = cnt;
        return o;
    endfunction

    function automatic obs_t sample_obs();
        return mk(running, sample_strobe, underrun, src.s_ready, int'(phase), int'(fill_level),
                  v_out, underrun_count);
    endfunction

    function automatic void add(bit en, bit sv, logic [14:0] sd, obs_t e);
        vec_t r;
        r.en = en; r.sv = sv; r.sd = sd; r.exp = e;
        vecs.push_back(r);
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic run_main();
        logic [14:0] exp_q[$];
        logic [14:0] nd;
        logic [14:0] want;
        obs_t o;

        // Reset state
        repeat (3) step();
        chk("reset_state", 64'(sample_obs()), 64'(mk(0, 0, 0, 0, 0, 0, 0, 0)));
        reset = 1'b1;
        step();
        chk("idle_after_reset", 64'(sample_obs()), 64'(mk(0, 0, 0, 0, 0, 0, 0, 0)));

        // Prime, two strobes, one underrun, recovery
        add(1, 0, 0, mk(0, 0, 0, 1, 0, 0, 0, 0));
        add(1, 1, 15'h100, mk(0, 0, 0, 1, 0, 1, 0, 0));
        add(1, 1, 15'h200, mk(0, 0, 0, 1, 0, 2, 0, 0));
        add(1, 0, 0, mk(1, 1, 0, 1, 0, 1, 15'h100, 0));
        for (int p = 1; p < 8; p++) add(1, 0, 0, mk(1, 0, 0, 1, p, 1, 15'h100, 0));
        add(1, 0, 0, mk(1, 1, 0, 1, 0, 0, 15'h200, 0));
        for (int p = 1; p < 8; p++) add(1, 0, 0, mk(1, 0, 0, 1, p, 0, 15'h200, 0));
        add(1, 0, 0, mk(1, 1, 1, 1, 0, 0, 15'h200, 1));
        add(1, 1, 15'h300, mk(1, 0, 0, 1, 1, 1, 15'h200, 1));
        for (int p = 2; p < 8; p++) add(1, 0, 0, mk(1, 0, 0, 1, p, 1, 15'h200, 1));
        add(1, 0, 0, mk(1, 1, 0, 1, 0, 0, 15'h300, 1));

        for (int i = 0; i < vecs.size(); i++) begin
            enable = vecs[i].en;
            src.s_valid = vecs[i].sv;
            src.s_data = vecs[i].sd;
            step();
            o = sample_obs();
            total_cnt++;
            if (o === vecs[i].exp) pass_cnt++;
            else $display("FAIL vec%0d: got %h expected %h", i, o, vecs[i].exp);
        end

        // Continuous source: FIFO fills, back-pressure, order preserved
        nd = 15'h400;
        for (int c = 0; c < 40; c++) begin
            src.s_valid = 1'b1;
            src.s_data = nd;
            if (src.s_ready) begin
                exp_q.push_back(nd);
                nd = nd + 15'd1;
            end
            step();
            if (sample_strobe) begin
                want = (exp_q.size() > 0) ? exp_q.pop_front() : 15'h7FFF;
                chk($sformatf("full_order_c%0d", c), 64'(v_out), 64'(want));
                chk($sformatf("full_no_ur_c%0d", c), 64'(underrun), 64'(0));
            end
            if (c == 3)
                chk("full_backpressure", 64'({fill_level, src.s_ready}), 64'({3'd4, 1'b0}));
            if (c == 7)
                chk("full_pop_frees", 64'({sample_strobe, fill_level, src.s_ready, v_out}),
                    64'({1'b1, 3'd3, 1'b1, 15'h400}));
        end
        chk("full_last_strobe", 64'({sample_strobe, fill_level, v_out}),
            64'({1'b1, 3'd3, 15'h404}));

        // Enable drop with three samples buffered
        enable = 1'b0;
        src.s_valid = 1'b0;
        step();
        chk("disable_flush", 64'(sample_obs()), 64'(mk(0, 0, 0, 0, 0, 0, 0, 1)));
        enable = 1'b1;
        step();
        chk("reenable_prime", 64'(sample_obs()), 64'(mk(0, 0, 0, 1, 0, 0, 0, 1)));
        src.s_valid = 1'b1; src.s_data = 15'h900;
        step();
        src.s_valid = 1'b0;
        step();
        chk("prime_waits", 64'(sample_obs()), 64'(mk(0, 0, 0, 1, 0, 1, 0, 1)));
        src.s_valid = 1'b1; src.s_data = 15'hA00;
        step();
        src.s_valid = 1'b0;
        chk("prime_two", 64'(sample_obs()), 64'(mk(0, 0, 0, 1, 0, 2, 0, 1)));
        step();
        chk("rerun_first", 64'(sample_obs()), 64'(mk(1, 1, 0, 1, 0, 1, 15'h900, 1)));

        // Reset mid-RUN wins over running state
        repeat (3) step();
        reset = 1'b0;
        src.s_valid = 1'b1; src.s_data = 15'h123;
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("reset_mid_run%0d", k), 64'(sample_obs()),
                64'(mk(0, 0, 0, 0, 0, 0, 0, 0)));
        end
        reset = 1'b1;
        src.s_valid = 1'b0;
        step();
        chk("post_reset_prime", 64'(sample_obs()), 64'(mk(0, 0, 0, 1, 0, 0, 0, 0)));
    endtask

    task automatic run_sat();
        int n;
        bit done;
        n = 0;
        done = 1'b0;
        src2.s_valid = 1'b0;
        src2.s_data = '0;
        repeat (2) @(negedge clk2);
        rst2 = 1'b1;
        en2 = 1'b1;
        @(negedge clk2);
        src2.s_valid = 1'b1;
        src2.s_data = 15'h55;
        @(negedge clk2);
        src2.s_valid = 1'b0;
        for (int c = 0; c < 140000 && !done; c++) begin
            @(negedge clk2);
            if (ur2) begin
                n++;
                if (n == 1) chk("sat_first", 64'(cnt2), 64'(1));
                if (n == 65534) chk("sat_fffe", 64'(cnt2), 64'(16'hFFFE));
                if (n == 65535) chk("sat_ffff", 64'(cnt2), 64'(16'hFFFF));
                if (n == 65540) begin
                    chk("sat_hold", 64'(cnt2), 64'(16'hFFFF));
                    chk("sat_v_held", 64'(v2), 64'(15'h55));
                    done = 1'b1;
                end
            end
        end
        if (!done) chk("sat_timeout", 64'(n), 64'(65540));
    endtask

    initial begin
        src.s_valid = 1'b0;
        src.s_data = '0;
        fork
            run_main();
            run_sat();
        join
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
